// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake,
// redirect inputs and status outputs.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        PCSel;
  logic [31:0] alu_result;
  logic [31:0] fetch_count;
  logic        misalign_err;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    output Instruction, instr_valid,
    input  instr_ready,
    output pc_out,
    input  PCSel, alu_result,
    output fetch_count, misalign_err, fetch_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    input  Instruction, instr_valid,
    output instr_ready,
    input  pc_out,
    output PCSel, alu_result,
    input  fetch_count, misalign_err, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit of the single-issue RISC-V core: owns the PC, fetches one word at a
// time from instruction memory, hands it to decode and applies redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input logic                 clock,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc_out;
  logic [31:0]      r_fetch_count;
  logic             r_imem_req;
  logic             r_instr_valid;
  logic             r_misalign_err;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_handshake;
  logic             w_misaligned;
  logic [31:0]      w_next_pc;

  assign w_handshake  = r_instr_valid & bus.instr_ready;
  assign w_misaligned = bus.PCSel & (bus.alu_result[1:0] != 2'b00);
  assign w_next_pc    = bus.PCSel ? bus.alu_result : (r_pc + 32'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= RESET_PC;
      r_instr        <= NOP;
      r_instr_valid  <= 1'b0;
      r_pc_out       <= RESET_PC;
      r_fetch_count  <= '0;
      r_misalign_err <= 1'b0;
      r_fetch_err    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
          r_cnt       <= '0;
          r_state     <= REQ;
        end
        REQ: begin
          // A response in the final allowed cycle still wins over the timeout.
          if (bus.imem_valid) begin
            r_instr       <= bus.imem_rdata;
            r_pc_out      <= r_pc;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_cnt         <= '0;
            r_state       <= HOLD;
          end else if (r_cnt == CNT_MAX) begin
            r_fetch_err <= 1'b1;
            r_imem_req  <= 1'b0;
            r_cnt       <= r_cnt + 1'b1;
            r_state     <= HALT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP;
            if (w_misaligned) begin
              r_misalign_err <= 1'b1;
              r_state        <= HALT;
            end else begin
              r_pc        <= w_next_pc;
              r_imem_addr <= w_next_pc;
              r_imem_req  <= 1'b1;
              r_state     <= REQ;
            end
          end
        end
        HALT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign bus.imem_req     = r_imem_req;
  assign bus.imem_addr    = r_imem_addr;
  assign bus.Instruction  = r_instr;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.pc_out       = r_pc_out;
  assign bus.fetch_count  = r_fetch_count;
  assign bus.misalign_err = r_misalign_err;
  assign bus.fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetch addresses and fetched words are
// queued when stimulus is driven and compared when the unit produces them.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .NOP      (NOP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_count = 32'd0;
  logic [31:0] q_addr[$];
  logic [63:0] q_instr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], 16'h0013} ^ 32'h1357_0000;
  endfunction

  task automatic chk_reset_vals(input string ph);
    chk({ph, "_req"},   bus.imem_req,     32'd0);
    chk({ph, "_addr"},  bus.imem_addr,    RESET_PC);
    chk({ph, "_instr"}, bus.Instruction,  NOP);
    chk({ph, "_ival"},  bus.instr_valid,  32'd0);
    chk({ph, "_pc"},    bus.pc_out,       RESET_PC);
    chk({ph, "_cnt"},   bus.fetch_count,  32'd0);
    chk({ph, "_mis"},   bus.misalign_err, 32'd0);
    chk({ph, "_ferr"},  bus.fetch_err,    32'd0);
  endtask

  // Wait for a request, check its address, answer after w idle request cycles.
  task automatic serve(input int w);
    logic [31:0] a;
    a = 32'hxxxx_xxxx;
    for (int i = 0; i < 40 && !bus.imem_req; i++) @(negedge clock);
    chk("req_seen", bus.imem_req, 32'd1);
    chk("sb_addr_avail", 32'(q_addr.size() != 0), 32'd1);
    if (q_addr.size() != 0) a = q_addr.pop_front();
    chk("imem_addr", bus.imem_addr, a);
    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      chk("req_held", bus.imem_req, 32'd1);
      chk("addr_stable", bus.imem_addr, a);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = mem_word(a);
    q_instr.push_back({mem_word(a), a});
    @(negedge clock);
    bus.imem_valid = 1'b0;
    chk("req_drop", bus.imem_req, 32'd0);
    chk("ivalid_rise", bus.instr_valid, 32'd1);
    chk("no_fetch_err", bus.fetch_err, 32'd0);
  endtask

  // Check the held word, stall for 'hold' cycles, then retire it with a redirect choice.
  task automatic take(input int hold, input logic sel, input logic [31:0] tgt);
    logic [63:0] e;
    logic [31:0] nxt;
    e = 64'hxxxx_xxxx_xxxx_xxxx;
    for (int i = 0; i < 40 && !bus.instr_valid; i++) @(negedge clock);
    chk("ivalid_seen", bus.instr_valid, 32'd1);
    chk("sb_instr_avail", 32'(q_instr.size() != 0), 32'd1);
    if (q_instr.size() != 0) e = q_instr.pop_front();
    chk("instr", bus.Instruction, e[63:32]);
    chk("pc_out", bus.pc_out, e[31:0]);
    chk("req_in_hold", bus.imem_req, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.instr_ready = 1'b0;
      bus.PCSel       = 1'b1;
      bus.alu_result  = 32'h0000_0100;
      bus.imem_valid  = i[0];
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clock);
      chk("hold_instr", bus.Instruction, e[63:32]);
      chk("hold_pc", bus.pc_out, e[31:0]);
      chk("hold_req", bus.imem_req, 32'd0);
      chk("hold_ival", bus.instr_valid, 32'd1);
    end
    bus.imem_valid  = 1'b0;
    bus.instr_ready = 1'b1;
    bus.PCSel       = sel;
    bus.alu_result  = tgt;
    @(negedge clock);
    bus.instr_ready = 1'b0;
    bus.PCSel       = 1'b0;
    exp_count++;
    chk("fetch_count", bus.fetch_count, exp_count);
    chk("instr_nop", bus.Instruction, NOP);
    chk("ival_drop", bus.instr_valid, 32'd0);
    nxt = sel ? tgt : e[31:0] + 32'd4;
    if (sel && tgt[1:0] != 2'b00) begin
      chk("misalign_set", bus.misalign_err, 32'd1);
      chk("misalign_req", bus.imem_req, 32'd0);
    end else begin
      chk("misalign_clr", bus.misalign_err, 32'd0);
      chk("req_next", bus.imem_req, 32'd1);
      q_addr.push_back(nxt);
    end
  endtask

  initial begin
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.PCSel       = 1'b0;
    bus.alu_result  = 32'h0;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clock);
    chk("first_req", bus.imem_req, 32'd1);

    // Normal flow, stall, branch, late response, PC wrap
    q_addr.push_back(RESET_PC);
    serve(0);  take(0, 1'b0, 32'h0);
    serve(0);  take(5, 1'b0, 32'h0);
    serve(0);  take(0, 1'b1, 32'h0000_0040);
    serve(TIMEOUT - 1); take(0, 1'b1, 32'hFFFF_FFFC);
    serve(0);  take(0, 1'b0, 32'h0);
    serve(0);  take(0, 1'b1, 32'h0000_0042);

    // Halted after misaligned redirect
    bus.imem_valid = 1'b1;
    repeat (4) @(negedge clock);
    bus.imem_valid = 1'b0;
    chk("halt_req", bus.imem_req, 32'd0);
    chk("halt_ival", bus.instr_valid, 32'd0);
    chk("halt_cnt", bus.fetch_count, exp_count);
    chk("halt_mis", bus.misalign_err, 32'd1);

    // Reset from HALT, then asynchronous reset in the middle of REQ
    reset = 1'b1;
    @(negedge clock);
    chk_reset_vals("halt_rst");
    reset = 1'b0;
    exp_count = 32'd0;
    q_addr.delete();
    q_instr.delete();
    @(negedge clock);
    chk("req_before_rst", bus.imem_req, 32'd1);
    #3 reset = 1'b1;
    #1 chk_reset_vals("midreq");
    @(negedge clock);
    reset = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hBAD0_0BAD;
    @(negedge clock);
    bus.imem_valid = 1'b0;
    chk("idle_resp_ignored", bus.instr_valid, 32'd0);
    q_addr.push_back(RESET_PC);
    serve(0);  take(0, 1'b0, 32'h0);

    // Memory timeout
    for (int i = 0; i < 40 && !bus.imem_req; i++) @(negedge clock);
    chk("to_req_seen", bus.imem_req, 32'd1);
    chk("to_addr", bus.imem_addr, 32'h4);
    repeat (TIMEOUT - 1) @(negedge clock);
    chk("to_req_last", bus.imem_req, 32'd1);
    chk("to_err_early", bus.fetch_err, 32'd0);
    @(negedge clock);
    chk("to_err", bus.fetch_err, 32'd1);
    chk("to_req_drop", bus.imem_req, 32'd0);
    bus.imem_valid = 1'b1;
    repeat (3) @(negedge clock);
    bus.imem_valid = 1'b0;
    chk("to_err_sticky", bus.fetch_err, 32'd1);
    chk("to_halt_req", bus.imem_req, 32'd0);
    chk("to_halt_ival", bus.instr_valid, 32'd0);
    chk("to_halt_cnt", bus.fetch_count, exp_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch side of the single-issue RISC-V core, and the producer of the `Instruction` word consumed by the control unit.
- Owns the PC register.
- Runs a request/valid handshake to instruction memory.
- Presents each fetched word to decode with a valid/ready handshake.
- Applies branch/jump redirects using `PCSel` and the ALU-computed target.
- Detects misaligned redirects and memory timeouts, then halts.

Parameters:
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset.
- `TIMEOUT`, `16`: maximum cycles `imem_req` may stay high without `imem_valid` before a fetch error is raised (minimum 1).
- `NOP`, `32'h0000_0013`: value driven on `Instruction` while no valid word is held (`addi x0,x0,0`).

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `imem_req`, out, 1: fetch request to instruction memory.
- `imem_addr`, out, 32: fetch address; stable while `imem_req`=1.
- `imem_rdata`, in, 32: memory read data; sampled only when `imem_valid`=1 in state REQ.
- `imem_valid`, in, 1: read data valid.
- `Instruction`, out, 32: instruction word to decode.
- `instr_valid`, out, 1: `Instruction` holds a fetched word.
- `instr_ready`, in, 1: decode/execute accepts (retires) the current instruction.
- `pc_out`, out, 32: address of the word on `Instruction`.
- `PCSel`, in, 1: redirect request; meaningful only in the handshake cycle.
- `alu_result`, in, 32: redirect target; meaningful only in the handshake cycle.
- `fetch_count`, out, 32: number of instructions accepted by decode.
- `misalign_err`, out, 1: sticky; a redirect target had bits [1:0] != 0.
- `fetch_err`, out, 1: sticky; memory timeout occurred.

Behaviour:
- Reset (async, immediate) sets:
  - state = IDLE; pc = `RESET_PC`
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `Instruction`=`NOP`, `instr_valid`=0, `pc_out`=`RESET_PC`
  - `fetch_count`=0, both error flags 0, timeout counter 0.
- States: IDLE, REQ, HOLD, HALT.
- IDLE: lasts exactly one cycle after reset deasserts, then goes to REQ. `imem_req`=0.
- REQ:
  - `imem_req`=1 and `imem_addr`=pc, both registered outputs.
  - Timeout counter increments each cycle in REQ while `imem_valid`=0.
  - On `imem_valid`=1: latch `Instruction`<=`imem_rdata`, `pc_out`<=pc, `instr_valid`<=1, `imem_req`<=0, clear the counter, go to HOLD.
  - Otherwise, when the counter reaches `TIMEOUT`: set `fetch_err`, drop `imem_req`, go to HALT.
  - `imem_valid` in the same cycle as the timeout takes priority over the timeout; the data is accepted.
- HOLD:
  - `instr_valid`=1; `Instruction` and `pc_out` stay stable.
  - `imem_valid` is ignored.
  - Handshake cycle = `instr_valid` & `instr_ready`. In that cycle `fetch_count` increments (wraps at 2^32) and `instr_valid`<=0.
  - `Instruction`<=`NOP` on the handshake.
  - Next pc = `PCSel` ? `alu_result` : pc+4. pc+4 wraps modulo 2^32 (`32'hFFFF_FFFC` → 0).
  - If `PCSel`=1 and `alu_result[1:0]`!=0: set `misalign_err`, pc unchanged, go to HALT. Otherwise go to REQ with the new pc.
  - `PCSel` and `alu_result` are ignored outside the handshake cycle.
- HALT:
  - Terminal until reset. `imem_req`=0, `instr_valid`=0.
  - Errors stay asserted; `fetch_count` is frozen.
- Latency:
  - First `imem_req` appears in the 2nd cycle after reset release.
  - `imem_valid` in cycle N gives `instr_valid` in N+1.
  - Handshake in cycle M gives the next `imem_req` in M+1.
  - Peak throughput with zero-wait memory and `instr_ready` held at 1: one instruction per 2 cycles.
- Reset mid-operation (in REQ or HOLD) aborts immediately. Any in-flight memory response after reset is ignored, because it arrives in IDLE.

Test Plan:
- Reset release, memory returns `32'h00500093` one cycle after the request, `instr_ready`=1 → `imem_addr`=0, then `Instruction`=`32'h00500093` with `pc_out`=0, then a request at address 4; `fetch_count`=1.
- `instr_ready` held 0 for 5 cycles in HOLD while `imem_valid` toggles → `Instruction`/`pc_out` stable, `imem_req`=0; on release the next fetch is at pc+4.
- Handshake with `PCSel`=1, `alu_result`=`32'h0000_0040` → next `imem_addr`=`32'h40`; `PCSel`=1 outside the handshake cycle → no effect.
- Handshake with `PCSel`=1, `alu_result`=`32'h0000_0042` → `misalign_err`=1, HALT, `imem_req` stays 0.
- `imem_valid` withheld for `TIMEOUT`=16 cycles → `fetch_err`=1, `imem_req`=0. Valid arriving on the 16th cycle instead → accepted, no error.
- `pc_out`=`32'hFFFF_FFFC`, handshake with `PCSel`=0 → next `imem_addr`=0. Reset asserted during REQ → all outputs at reset values immediately.
